lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 lsu_req_valid  input  1  core presents a load/store request.
REQ-005 lsu_req_ready  output  1  block accepts a request; transfer occurs when valid&ready at a clk edge.
REQ-006 lsu_we  input  1  1=store, 0=load.
REQ-007 lsu_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 lsu_addr  input  32  byte address.
REQ-009 lsu_wdata  input  32  store data, right-aligned.
REQ-010 lsu_rsp_valid  output  1  one-cycle completion pulse.
REQ-011 lsu_rdata  output  32  extended load result, feeding writeback-select input.
REQ-012 lsu_err  output  1  misaligned or illegal funct3, qualified by lsu_rsp_valid.
REQ-013 mem_req  output  1  bus request.
REQ-014 mem_addr  output  32  word address: lsu_addr with [1:0]=00.
REQ-015 mem_we, mem_wstrb[3:0], mem_wdata[31:0]  output  bus write control and data.
REQ-016 mem_gnt  input  1  bus accepts the request this cycle.
REQ-017 mem_rvalid  input  1, mem_rdata  input  32  read data return.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT and RESP.
REQ-019 lsu_req_ready SHALL be (state==IDLE) and not rst.
REQ-020 On accept, the block SHALL latch we, funct3, addr and wdata; any later change on lsu_* inputs SHALL have no effect until RESP completes.
REQ-021 IDLE transitions:
- on accept with misalignment (H at addr[0]=1; W at addr[1:0]!=0) or funct3 in {011,110,111}: go to RESP with lsu_err=1 and no bus access;
- otherwise: go to REQ.
REQ-022 In REQ, mem_req SHALL be 1, and mem_addr/mem_we/mem_wstrb/mem_wdata SHALL be held stable until mem_gnt.
REQ-023 REQ transitions:
- on mem_gnt for a store: go to RESP;
- on mem_gnt for a load: go to WAIT, or go directly to RESP if mem_rvalid is also 1 that cycle.
REQ-024 In WAIT, on mem_rvalid the block SHALL register the extracted load data and go to RESP; mem_req SHALL be 0 in WAIT.
REQ-025 mem_rvalid SHALL be ignored in IDLE and RESP, and in REQ without mem_gnt.
REQ-026 In RESP, lsu_rsp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; a new request is accepted no earlier than the following cycle.
REQ-027 Store byte lanes:
- SB: mem_wdata={4{wdata[7:0]}}, mem_wstrb=0001<<addr[1:0];
- SH: mem_wdata={2{wdata[15:0]}}, mem_wstrb=0011<<addr[1:0];
- SW: mem_wdata=wdata, mem_wstrb=1111.
REQ-028 For loads, mem_wstrb SHALL be 0000 and mem_we SHALL be 0.
REQ-029 Load extraction: lane=mem_rdata>>(8*addr[1:0]); B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through unchanged.
REQ-030 lsu_rdata SHALL be registered, SHALL be 0 on store or error responses, and SHALL hold its value between responses.
REQ-031 Latency, counted from the accept edge N:
- aligned load with mem_gnt in the first REQ cycle and mem_rvalid one cycle later: lsu_rsp_valid in cycle N+3;
- store with immediate mem_gnt: cycle N+2;
- error: cycle N+1.
REQ-032 lsu_err SHALL be 0 whenever lsu_rsp_valid is 0.

Reset
REQ-033 While rst=1, at the clock edge the state SHALL become IDLE and mem_req, lsu_rsp_valid, lsu_err, mem_we, mem_wstrb, mem_addr, mem_wdata and lsu_rdata SHALL be 0; lsu_req_ready SHALL be 0 during the reset cycle.
REQ-034 Reset asserted in REQ or WAIT SHALL abort the access: mem_req SHALL be 0 from the following cycle, no response SHALL be issued, and a subsequent stray mem_rvalid SHALL be ignored.

Verification
REQ-035 LB from addr 0x103, mem_rdata=0x80FF_1234 -> lsu_rdata=0xFFFF_FF80; LBU from the same address -> 0x0000_0080.
REQ-036 SH of wdata 0x0000_BEEF to addr 0x202 -> mem_addr=0x200, mem_wstrb=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, held for 3 cycles with mem_gnt=0, then lsu_rsp_valid pulses once.
REQ-037 LW to addr 0x006 -> lsu_rsp_valid=1 and lsu_err=1 at N+1, mem_req never asserted; funct3=011 -> same response.
REQ-038 LH from 0x002 with mem_gnt and mem_rvalid in the same REQ cycle, mem_rdata=0x7FFF_0000 -> lsu_rdata=0x0000_7FFF, lsu_rsp_valid at N+2.
REQ-039 Reset asserted in WAIT, then mem_rvalid=1 two cycles later -> no lsu_rsp_valid, lsu_rdata=0, and lsu_req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core request/response and memory bus signals of the load/store unit
//
// Core side : lsu_req_valid/lsu_req_ready handshake, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
//             lsu_rsp_valid pulse with lsu_rdata and lsu_err.
// Memory side: mem_req/mem_gnt handshake, mem_addr, mem_we, mem_wstrb, mem_wdata,
//             mem_rvalid with mem_rdata.
// slave modport is the LSU's view; master modport is the core plus memory environment.
interface lsu_if;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  lsu_req_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_err,
        output mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata
    );

    modport master (
        output lsu_req_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_err,
        input  mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit bridging core requests to a word bus
//
// clk : rising-edge clock
// rst : synchronous active-high reset
// bus : lsu_if.slave, core request/response and memory bus
module lsu (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state, state_next;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        mem_we_q;

    logic        accept;
    logic        req_bad;
    logic        load_now;
    logic [3:0]  wstrb_new;
    logic [31:0] wdata_new;
    logic [31:0] lane;
    logic [31:0] load_data;

    assign accept = bus.lsu_req_valid && bus.lsu_req_ready;

    // Misalignment or reserved funct3 is resolved at accept time so no bus access is made.
    always_comb begin
        req_bad = 1'b0;
        case (bus.lsu_funct3)
            3'b000, 3'b100: req_bad = 1'b0;
            3'b001, 3'b101: req_bad = bus.lsu_addr[0];
            3'b010:         req_bad = |bus.lsu_addr[1:0];
            default:        req_bad = 1'b1;
        endcase
    end

    // Store lane replication; the strobe selects which replica the memory keeps.
    always_comb begin
        wstrb_new = 4'b0000;
        wdata_new = 32'd0;
        if (bus.lsu_we) begin
            case (bus.lsu_funct3[1:0])
                2'b00: begin
                    wdata_new = {4{bus.lsu_wdata[7:0]}};
                    wstrb_new = 4'b0001 << bus.lsu_addr[1:0];
                end
                2'b01: begin
                    wdata_new = {2{bus.lsu_wdata[15:0]}};
                    wstrb_new = 4'b0011 << bus.lsu_addr[1:0];
                end
                default: begin
                    wdata_new = bus.lsu_wdata;
                    wstrb_new = 4'b1111;
                end
            endcase
        end
    end

    assign lane = bus.mem_rdata >> {addr_lo_q, 3'b000};

    always_comb begin
        load_data = lane;
        case (funct3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'd0, lane[7:0]};
            3'b101:  load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    // Read data is only honoured together with a grant in REQ, or in WAIT.
    assign load_now = bus.mem_rvalid && !we_q &&
                      ((state == REQ && bus.mem_gnt) || state == WAIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = req_bad ? RESP : REQ;
            REQ:  if (bus.mem_gnt) state_next = (we_q || bus.mem_rvalid) ? RESP : WAIT;
            WAIT: if (bus.mem_rvalid) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            mem_we_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q      <= bus.lsu_we;
                funct3_q  <= bus.lsu_funct3;
                addr_lo_q <= bus.lsu_addr[1:0];
                err_q     <= req_bad;
                if (req_bad) begin
                    rdata_q <= 32'd0;
                end else begin
                    mem_addr_q  <= {bus.lsu_addr[31:2], 2'b00};
                    mem_wdata_q <= wdata_new;
                    mem_wstrb_q <= wstrb_new;
                    mem_we_q    <= bus.lsu_we;
                end
            end
            if (state == REQ && bus.mem_gnt && we_q) begin
                rdata_q <= 32'd0;
            end
            if (load_now) begin
                rdata_q <= load_data;
            end
        end
    end

    assign bus.lsu_req_ready = (state == IDLE) && !rst;
    assign bus.lsu_rsp_valid = (state == RESP);
    assign bus.lsu_err       = (state == RESP) && err_q;
    assign bus.lsu_rdata     = rdata_q;
    assign bus.mem_req       = (state == REQ);
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_wstrb     = mem_wstrb_q;
    assign bus.mem_wdata     = mem_wdata_q;
endmodule
